cpu_phase_sequencer: RTL and testbench



---
 rtl/cpu_phase_sequencer.sv | 123 ++++++++++++
 tb/tb_cpu_phase_sequencer.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/cpu_phase_sequencer.sv
// Three-phase instruction sequencer (fetch/decode/execute strobes) with free-run and
// single-step modes, fetch wait states with timeout, halt handling and retired-instruction count.
module cpu_phase_sequencer #(
    parameter int COUNT_W  = 16,
    parameter int WAIT_W   = 4,
    parameter int WAIT_MAX = 7
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               run,
    input  logic               step,
    input  logic               halt_req,
    input  logic               mem_ready,
    input  logic               clear_halt,
    output logic               clock_1,
    output logic               clock_2,
    output logic               clock_3,
    output logic               busy,
    output logic               halted,
    output logic               fault,
    output logic [COUNT_W-1:0] instr_count
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_P1   = 3'd1,
        S_P2   = 3'd2,
        S_P3   = 3'd3,
        S_HALT = 3'd4
    } state_t;

    localparam logic [WAIT_W-1:0] WAIT_LIM = WAIT_W'(WAIT_MAX);

    state_t            state;
    state_t            state_nxt;
    logic [WAIT_W-1:0] wait_cnt;
    logic [WAIT_W-1:0] wait_cnt_nxt;
    logic              step_mode;
    logic              step_mode_nxt;
    logic              fault_nxt;
    logic              retire;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_IDLE;
            wait_cnt    <= '0;
            step_mode   <= 1'b0;
            fault       <= 1'b0;
            instr_count <= '0;
        end else begin
            state     <= state_nxt;
            wait_cnt  <= wait_cnt_nxt;
            step_mode <= step_mode_nxt;
            fault     <= fault_nxt;
            if (retire) begin
                instr_count <= instr_count + COUNT_W'(1);
            end
        end
    end

    always_comb begin
        state_nxt     = state;
        wait_cnt_nxt  = wait_cnt;
        step_mode_nxt = step_mode;
        fault_nxt     = fault;
        retire        = 1'b0;
        case (state)
            S_IDLE: begin
                // run has priority over step so both together means free-run
                if (run) begin
                    state_nxt     = S_P1;
                    step_mode_nxt = 1'b0;
                    wait_cnt_nxt  = '0;
                end else if (step) begin
                    state_nxt     = S_P1;
                    step_mode_nxt = 1'b1;
                    wait_cnt_nxt  = '0;
                end
            end
            S_P1: begin
                // a late mem_ready on the limit cycle still wins over the timeout
                if (mem_ready) begin
                    state_nxt = S_P2;
                end else if (wait_cnt < WAIT_LIM) begin
                    wait_cnt_nxt = wait_cnt + WAIT_W'(1);
                end else begin
                    state_nxt = S_HALT;
                    fault_nxt = 1'b1;
                end
            end
            S_P2: begin
                state_nxt = S_P3;
            end
            S_P3: begin
                retire = 1'b1;
                if (halt_req) begin
                    state_nxt = S_HALT;
                end else if (step_mode || !run) begin
                    state_nxt = S_IDLE;
                end else begin
                    state_nxt    = S_P1;
                    wait_cnt_nxt = '0;
                end
            end
            S_HALT: begin
                if (clear_halt) begin
                    state_nxt = S_IDLE;
                    fault_nxt = 1'b0;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    assign clock_1 = (state == S_P1);
    assign clock_2 = (state == S_P2);
    assign clock_3 = (state == S_P3);
    assign busy    = (state == S_P1) || (state == S_P2) || (state == S_P3);
    assign halted  = (state == S_HALT);

endmodule

// File: tb/tb_cpu_phase_sequencer.sv
// Randomized bench for cpu_phase_sequencer against a cycle-level reference model.
module tb_cpu_phase_sequencer;

    localparam int CW       = 4;
    localparam int WAIT_MAX = 7;

    logic          clock = 1'b0;
    logic          reset_n;
    logic          run, step, halt_req, mem_ready, clear_halt;
    logic          clock_1, clock_2, clock_3, busy, halted, fault;
    logic [CW-1:0] instr_count;

    int n_chk = 0;
    int n_bad = 0;

    // Reference model: what the sequencer is doing this cycle
    //   m_phase: 0 = waiting for work, 1/2/3 = fetch/decode/execute, 9 = stopped
    int m_phase;
    int m_waited;
    bit m_single;
    bit m_fault;
    int m_count;

    cpu_phase_sequencer #(.COUNT_W(CW), .WAIT_W(4), .WAIT_MAX(WAIT_MAX)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .run         (run),
        .step        (step),
        .halt_req    (halt_req),
        .mem_ready   (mem_ready),
        .clear_halt  (clear_halt),
        .clock_1     (clock_1),
        .clock_2     (clock_2),
        .clock_3     (clock_3),
        .busy        (busy),
        .halted      (halted),
        .fault       (fault),
        .instr_count (instr_count)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0d expected=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase  = 0;
        m_waited = 0;
        m_single = 0;
        m_fault  = 0;
        m_count  = 0;
    endtask

    task automatic model_clock();
        case (m_phase)
            0: begin
                if (run || step) begin
                    m_phase  = 1;
                    m_single = !run;
                    m_waited = 0;
                end
            end
            1: begin
                if (mem_ready) m_phase = 2;
                else if (m_waited < WAIT_MAX) m_waited++;
                else begin
                    m_phase = 9;
                    m_fault = 1;
                end
            end
            2: m_phase = 3;
            3: begin
                m_count = (m_count + 1) % (1 << CW);
                if (halt_req) m_phase = 9;
                else if (m_single || !run) m_phase = 0;
                else begin
                    m_phase  = 1;
                    m_waited = 0;
                end
            end
            default: begin
                if (clear_halt) begin
                    m_phase = 0;
                    m_fault = 0;
                end
            end
        endcase
    endtask

    task automatic compare_all();
        check_eq("clock_1", 32'(clock_1), 32'(m_phase == 1));
        check_eq("clock_2", 32'(clock_2), 32'(m_phase == 2));
        check_eq("clock_3", 32'(clock_3), 32'(m_phase == 3));
        check_eq("busy", 32'(busy), 32'(m_phase >= 1 && m_phase <= 3));
        check_eq("halted", 32'(halted), 32'(m_phase == 9));
        check_eq("fault", 32'(fault), 32'(m_fault));
        check_eq("instr_count", 32'(instr_count), 32'(m_count));
        check_eq("strobe_excl", 32'($countones({clock_1, clock_2, clock_3}) <= 1), 32'd1);
    endtask

    // Inputs change at negedge, DUT and model both advance on posedge, outputs checked at next negedge
    task automatic cycle(input bit r, input bit s, input bit h, input bit m, input bit c);
        run        = r;
        step       = s;
        halt_req   = h;
        mem_ready  = m;
        clear_halt = c;
        @(posedge clock);
        model_clock();
        @(negedge clock);
        compare_all();
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        run = 0; step = 0; halt_req = 0; mem_ready = 0; clear_halt = 0;
        model_reset();
        @(negedge clock);
        @(negedge clock);
        compare_all();
        reset_n = 1'b1;
    endtask

    initial begin
        int mode;
        int guard;

        do_reset();

        // Free-run with memory always ready: four instructions in twelve cycles after start
        for (int i = 0; i < 13; i++) cycle(1, 0, 0, 1, 0);
        check_eq("four_instr", 32'(instr_count), 32'd4);

        // Single-step twice from idle
        for (int i = 0; i < 4; i++) cycle(0, 0, 0, 1, 0);
        cycle(0, 1, 0, 1, 0);
        for (int i = 0; i < 5; i++) cycle(0, 0, 0, 1, 0);
        cycle(0, 1, 0, 1, 0);
        for (int i = 0; i < 5; i++) cycle(0, 0, 0, 1, 0);

        // Three wait states, then a timeout, then recovery
        cycle(1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) cycle(1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) cycle(1, 0, 0, 1, 0);
        for (int i = 0; i < 9; i++) cycle(1, 0, 0, 0, 0);
        check_eq("timeout_halt", 32'(halted), 32'd1);
        check_eq("timeout_fault", 32'(fault), 32'd1);
        for (int i = 0; i < 3; i++) cycle(1, 1, 0, 1, 0);
        cycle(0, 0, 0, 1, 1);
        check_eq("cleared_fault", 32'(fault), 32'd0);

        // Asynchronous reset while in decode
        guard = 0;
        while (m_phase != 2 && guard < 12) begin
            cycle(1, 0, 0, 1, 0);
            guard++;
        end
        check_eq("reach_decode", 32'(clock_2), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        check_eq("async_clock_2", 32'(clock_2), 32'd0);
        compare_all();
        @(negedge clock);
        reset_n = 1'b1;

        // Seventeen instructions wrap a 4-bit counter to 1
        for (int i = 0; i < 52; i++) cycle(1, 0, 0, 1, 0);
        check_eq("wrap17", 32'(instr_count), 32'd1);

        // Randomized segments with varying run/memory behaviour
        for (int seg = 0; seg < 40; seg++) begin
            mode = int'($urandom_range(0, 3));
            for (int i = 0; i < 60; i++) begin
                bit r, s, h, m, c;
                case (mode)
                    0:       r = ($urandom_range(0, 19) != 0);
                    1:       r = 1'($urandom_range(0, 1));
                    default: r = ($urandom_range(0, 7) == 0);
                endcase
                m = (mode == 3) ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 3) != 0);
                s = ($urandom_range(0, 5) == 0);
                h = ($urandom_range(0, 11) == 0);
                c = ($urandom_range(0, 7) == 0);
                cycle(r, s, h, m, c);
            end
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
